// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the pipeline hazard controller: forward-select
//   constants, the shadow-slot record kept for every in-flight instruction,
//   the default register index width and a register-match helper.
// ---------------------------------------------------------------------------
package pipe_pkg;

  // Default register index width (RV32: 32 architectural registers).
  localparam int REG_ADDR_W_DEF = 5;

  // Forward select value meaning "use the ID/EX register-file operand".
  localparam int FWD_RF = 0;

  // Shadow record of one in-flight instruction.
  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_W_DEF-1:0] rd;
    logic [REG_ADDR_W_DEF-1:0] rs1;
    logic [REG_ADDR_W_DEF-1:0] rs2;
    logic                      regwrite;
    logic                      memread;
  } slot_t;

  // An empty slot, used for bubbles and reset.
  localparam slot_t SLOT_EMPTY = slot_t'({($bits(slot_t)){1'b0}});

  // True when a non-x0 destination equals the given source register.
  // x0 is hard-wired to zero, so it can never be a real dependency.
  function automatic logic reg_match(input logic [REG_ADDR_W_DEF-1:0] rd,
                                     input logic [REG_ADDR_W_DEF-1:0] rs);
    return (rd != {REG_ADDR_W_DEF{1'b0}}) && (rd == rs);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
//   Bundles the ID-stage instruction fields, the EX branch outcome and the
//   hazard controls returned to the pipeline.
//   master : pipeline side (drives ID fields / branch, receives controls)
//   slave  : hazard controller side
//   Signals:
//     id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
//     id_regwrite, id_memread, ex_branch_taken   (pipeline -> controller)
//     pc_write, ifid_write, idex_bubble, flush_ifid, fwd_a, fwd_b,
//     stall_cnt, flush_cnt                       (controller -> pipeline)
// ---------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_W = pipe_pkg::REG_ADDR_W_DEF,
  parameter int SEL_W      = 2,
  parameter int CNT_W      = 32
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_rs1_used;
  logic                  id_rs2_used;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_regwrite;
  logic                  id_memread;
  logic                  ex_branch_taken;

  logic                  pc_write;
  logic                  ifid_write;
  logic                  idex_bubble;
  logic                  flush_ifid;
  logic [SEL_W-1:0]      fwd_a;
  logic [SEL_W-1:0]      fwd_b;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_regwrite, id_memread, ex_branch_taken,
    input  pc_write, ifid_write, idex_bubble, flush_ifid, fwd_a, fwd_b,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_regwrite, id_memread, ex_branch_taken,
    output pc_write, ifid_write, idex_bubble, flush_ifid, fwd_a, fwd_b,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/fwd_select.sv
// ---------------------------------------------------------------------------
// fwd_select
//   Priority encoder choosing the forwarding source for one EX operand.
//   Ports:
//     src   in  EX source register (taken from slot 0)
//     slots in  shadow slots 0..FWD_DEPTH (0 = EX)
//     sel   out 0 = register-file value, k = forward from slot k
//   The youngest producer (smallest k) wins; nothing is forwarded when
//   slot 0 is a bubble.
// ---------------------------------------------------------------------------
module fwd_select
  import pipe_pkg::*;
#(
  parameter  int FWD_DEPTH = 2,
  localparam int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic [REG_ADDR_W_DEF-1:0] src,
  input  slot_t                     slots [0:FWD_DEPTH],
  output logic [SEL_W-1:0]          sel
);

  logic [FWD_DEPTH:1] hit_s;
  logic               unused_slot_bits_s;

  // Per-stage producer match against the EX source register.
  always_comb begin
    hit_s = {FWD_DEPTH{1'b0}};
    for (int k = 1; k <= FWD_DEPTH; k++) begin
      hit_s[k] = slots[0].valid & slots[k].valid & slots[k].regwrite &
                 reg_match(slots[k].rd, src);
    end
  end

  // Priority encode: scan oldest to youngest so the youngest hit is kept.
  always_comb begin
    sel = SEL_W'(FWD_RF);
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      sel = hit_s[k] ? SEL_W'(k) : sel;
    end
  end

  // The full slot record is passed in; fields not needed here are folded away.
  always_comb begin
    unused_slot_bits_s = 1'b0;
    for (int k = 0; k <= FWD_DEPTH; k++) begin
      unused_slot_bits_s = unused_slot_bits_s ^ (^slots[k]);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Central hazard controller for the in-order pipeline. Tracks a shadow
//   record of each in-flight instruction from EX (slot 0) to the last
//   forwarding stage (slot FWD_DEPTH) and derives operand forwarding,
//   multi-cycle load-use stalls, taken-branch flushes and saturating
//   stall/flush counters.
//   Ports:
//     clk    in  rising-edge clock
//     reset  in  asynchronous, active-high reset
//     hz     slave side of pipeline_hazard_ctrl_if (ID fields, branch
//            outcome in; pc_write/ifid_write/idex_bubble/flush_ifid,
//            fwd_a/fwd_b and counters out)
//   All controls are combinational from the slots and ID inputs; only the
//   counters are registered.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter  int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter  int FWD_DEPTH  = 2,
  parameter  int LOAD_LAT   = 1,
  parameter  int CNT_W      = 32,
  localparam int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  pipeline_hazard_ctrl_if.slave  hz
);

  slot_t                 slots_r [0:FWD_DEPTH];
  slot_t                 id_slot_s;
  logic [REG_ADDR_W-1:0] id_rs1_s;
  logic [REG_ADDR_W-1:0] id_rs2_s;
  logic                  load_hit_s;
  logic                  flush_s;
  logic                  stall_s;
  logic                  enter_s;
  logic [SEL_W-1:0]      fwd_a_s;
  logic [SEL_W-1:0]      fwd_b_s;
  logic [CNT_W-1:0]      stall_cnt_r;
  logic [CNT_W-1:0]      flush_cnt_r;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign id_rs1_s = hz.id_rs1;
  assign id_rs2_s = hz.id_rs2;

  // Shadow record of the instruction currently in ID.
  always_comb begin
    id_slot_s          = SLOT_EMPTY;
    id_slot_s.valid    = hz.id_valid;
    id_slot_s.rd       = hz.id_rd;
    id_slot_s.rs1      = id_rs1_s;
    id_slot_s.rs2      = id_rs2_s;
    id_slot_s.regwrite = hz.id_regwrite;
    id_slot_s.memread  = hz.id_memread;
  end

  // Load-use detection: a load in slots 0..LOAD_LAT-1 cannot forward yet.
  // reg_match excludes x0, so a load to x0 never stalls.
  always_comb begin
    load_hit_s = 1'b0;
    for (int j = 0; j < LOAD_LAT; j++) begin
      load_hit_s = load_hit_s |
                   (slots_r[j].valid & slots_r[j].memread &
                    ((hz.id_rs1_used & reg_match(slots_r[j].rd, id_rs1_s)) |
                     (hz.id_rs2_used & reg_match(slots_r[j].rd, id_rs2_s))));
    end
  end

  // A taken branch kills the ID instruction, so it overrides any stall.
  assign flush_s = hz.ex_branch_taken;
  assign stall_s = load_hit_s & ~flush_s;
  assign enter_s = hz.id_valid & ~load_hit_s & ~flush_s;

  assign hz.pc_write    = ~stall_s;
  assign hz.ifid_write  = ~stall_s;
  assign hz.idex_bubble = stall_s | flush_s;
  assign hz.flush_ifid  = flush_s;
  assign hz.fwd_a       = fwd_a_s;
  assign hz.fwd_b       = fwd_b_s;
  assign hz.stall_cnt   = stall_cnt_r;
  assign hz.flush_cnt   = flush_cnt_r;

  // Shadow shift register: ID (or a bubble) into slot 0, older slots age by one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k <= FWD_DEPTH; k++) begin
        slots_r[k] <= SLOT_EMPTY;
      end
    end else begin
      slots_r[0] <= enter_s ? id_slot_s : SLOT_EMPTY;
      for (int k = 1; k <= FWD_DEPTH; k++) begin
        slots_r[k] <= slots_r[k-1];
      end
    end
  end

  // Saturating event counters for stalled and flushed cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_s) begin
        stall_cnt_r <= sat_inc(stall_cnt_r);
      end
      if (flush_s) begin
        flush_cnt_r <= sat_inc(flush_cnt_r);
      end
    end
  end

  fwd_select #(.FWD_DEPTH(FWD_DEPTH)) u_fwd_a (
    .src   (slots_r[0].rs1),
    .slots (slots_r),
    .sel   (fwd_a_s)
  );

  fwd_select #(.FWD_DEPTH(FWD_DEPTH)) u_fwd_b (
    .src   (slots_r[0].rs2),
    .slots (slots_r),
    .sel   (fwd_b_s)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//   Three controllers share one directed ID stream:
//     u0: FWD_DEPTH=2 LOAD_LAT=1 CNT_W=32
//     u1: FWD_DEPTH=3 LOAD_LAT=2 CNT_W=32
//     u2: FWD_DEPTH=2 LOAD_LAT=1 CNT_W=4
//   A per-design age list of issued instructions predicts every output on
//   every negedge; literal expectations pin the key scenarios.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = 5'd0, id_rs2 = 5'd0, id_rd = 5'd0;
  logic       id_rs1_used = 1'b0, id_rs2_used = 1'b0;
  logic       id_regwrite = 1'b0, id_memread = 1'b0, ex_branch_taken = 1'b0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_ADDR_W(5), .SEL_W(2), .CNT_W(32)) if0 ();
  pipeline_hazard_ctrl_if #(.REG_ADDR_W(5), .SEL_W(2), .CNT_W(32)) if1 ();
  pipeline_hazard_ctrl_if #(.REG_ADDR_W(5), .SEL_W(2), .CNT_W(4))  if2 ();

  assign if0.id_valid = id_valid;  assign if0.id_rs1 = id_rs1;  assign if0.id_rs2 = id_rs2;
  assign if0.id_rs1_used = id_rs1_used;  assign if0.id_rs2_used = id_rs2_used;
  assign if0.id_rd = id_rd;  assign if0.id_regwrite = id_regwrite;
  assign if0.id_memread = id_memread;  assign if0.ex_branch_taken = ex_branch_taken;
  assign if1.id_valid = id_valid;  assign if1.id_rs1 = id_rs1;  assign if1.id_rs2 = id_rs2;
  assign if1.id_rs1_used = id_rs1_used;  assign if1.id_rs2_used = id_rs2_used;
  assign if1.id_rd = id_rd;  assign if1.id_regwrite = id_regwrite;
  assign if1.id_memread = id_memread;  assign if1.ex_branch_taken = ex_branch_taken;
  assign if2.id_valid = id_valid;  assign if2.id_rs1 = id_rs1;  assign if2.id_rs2 = id_rs2;
  assign if2.id_rs1_used = id_rs1_used;  assign if2.id_rs2_used = id_rs2_used;
  assign if2.id_rd = id_rd;  assign if2.id_regwrite = id_regwrite;
  assign if2.id_memread = id_memread;  assign if2.ex_branch_taken = ex_branch_taken;

  pipeline_hazard_ctrl #(.FWD_DEPTH(2), .LOAD_LAT(1), .CNT_W(32)) u0 (.clk(clk), .reset(reset), .hz(if0));
  pipeline_hazard_ctrl #(.FWD_DEPTH(3), .LOAD_LAT(2), .CNT_W(32)) u1 (.clk(clk), .reset(reset), .hz(if1));
  pipeline_hazard_ctrl #(.FWD_DEPTH(2), .LOAD_LAT(1), .CNT_W(4))  u2 (.clk(clk), .reset(reset), .hz(if2));

  // ---------------- reference model ----------------
  typedef struct {
    bit       v;
    bit [4:0] rd, rs1, rs2;
    bit       rw, mr;
  } ins_t;

  // Age lists: element k is the instruction k cycles past entering EX.
  ins_t   q0[$], q1[$], q2[$];
  int     depth [3] = '{2, 3, 2};
  int     lat   [3] = '{1, 2, 1};
  int     cw    [3] = '{32, 32, 4};
  longint sc    [3] = '{0, 0, 0};
  longint fc    [3] = '{0, 0, 0};
  int     checks = 0;
  int     errors = 0;

  function automatic int fwd_of(input ins_t q[$], input int d, input bit use_rs2);
    bit [4:0] src;
    if (q.size() == 0) return 0;
    if (!q[0].v) return 0;
    src = use_rs2 ? q[0].rs2 : q[0].rs1;
    for (int k = 1; k <= d; k++)
      if (k < q.size() && q[k].v && q[k].rw && q[k].rd != 5'd0 && q[k].rd == src) return k;
    return 0;
  endfunction

  function automatic bit hit_of(input ins_t q[$], input int l);
    for (int j = 0; j < l; j++) begin
      if (j < q.size() && q[j].v && q[j].mr) begin
        if (id_rs1_used && id_rs1 != 5'd0 && q[j].rd == id_rs1) return 1'b1;
        if (id_rs2_used && id_rs2 != 5'd0 && q[j].rd == id_rs2) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic longint sat(input longint c, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (c > mx) ? mx : c;
  endfunction

  task automatic chk(input string nm, input int m, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got %0d expected %0d", nm, m, $time, got, exp);
    end
  endtask

  // Advance the model on each clock edge; reset empties it.
  always @(posedge clk or posedge reset) begin
    ins_t nw, bub;
    bit   h;
    bub = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0};
    nw  = '{id_valid, id_rd, id_rs1, id_rs2, id_regwrite, id_memread};
    if (reset) begin
      q0.delete(); q1.delete(); q2.delete();
      sc = '{0, 0, 0};
      fc = '{0, 0, 0};
    end else begin
      h = hit_of(q0, lat[0]);
      q0.push_front((id_valid && !h && !ex_branch_taken) ? nw : bub);
      if (q0.size() > 4) void'(q0.pop_back());
      if (h && !ex_branch_taken) sc[0]++;
      h = hit_of(q1, lat[1]);
      q1.push_front((id_valid && !h && !ex_branch_taken) ? nw : bub);
      if (q1.size() > 4) void'(q1.pop_back());
      if (h && !ex_branch_taken) sc[1]++;
      h = hit_of(q2, lat[2]);
      q2.push_front((id_valid && !h && !ex_branch_taken) ? nw : bub);
      if (q2.size() > 4) void'(q2.pop_back());
      if (h && !ex_branch_taken) sc[2]++;
      if (ex_branch_taken) begin
        fc[0]++; fc[1]++; fc[2]++;
      end
    end
  end

  task automatic cmp_dut(input int m, input longint pcw, input longint ifw, input longint bub,
                         input longint fl, input longint fa, input longint fb,
                         input longint s, input longint f);
    ins_t q[$];
    bit   st;
    case (m)
      0:       q = q0;
      1:       q = q1;
      default: q = q2;
    endcase
    st = hit_of(q, lat[m]) && !ex_branch_taken;
    chk("pc_write", m, pcw, longint'(!st));
    chk("ifid_write", m, ifw, longint'(!st));
    chk("idex_bubble", m, bub, longint'(st || ex_branch_taken));
    chk("flush_ifid", m, fl, longint'(ex_branch_taken));
    chk("fwd_a", m, fa, longint'(fwd_of(q, depth[m], 1'b0)));
    chk("fwd_b", m, fb, longint'(fwd_of(q, depth[m], 1'b1)));
    chk("stall_cnt", m, s, sat(sc[m], cw[m]));
    chk("flush_cnt", m, f, sat(fc[m], cw[m]));
  endtask

  // Compare every design against the model mid-cycle.
  always @(negedge clk) begin
    cmp_dut(0, if0.pc_write, if0.ifid_write, if0.idex_bubble, if0.flush_ifid,
            if0.fwd_a, if0.fwd_b, if0.stall_cnt, if0.flush_cnt);
    cmp_dut(1, if1.pc_write, if1.ifid_write, if1.idex_bubble, if1.flush_ifid,
            if1.fwd_a, if1.fwd_b, if1.stall_cnt, if1.flush_cnt);
    cmp_dut(2, if2.pc_write, if2.ifid_write, if2.idex_bubble, if2.flush_ifid,
            if2.fwd_a, if2.fwd_b, if2.stall_cnt, if2.flush_cnt);
  end

  // ---------------- stimulus ----------------
  task automatic put(input bit v, input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2,
                     input bit u1, input bit u2, input bit rw, input bit mr, input bit br);
    id_valid = v; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_rs1_used = u1; id_rs2_used = u2; id_regwrite = rw; id_memread = mr;
    ex_branch_taken = br;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic add_i(input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2);
    put(1'b1, rd, rs1, rs2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic ld_i(input bit [4:0] rd, input bit [4:0] rs1);
    put(1'b1, rd, rs1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic nop_i();
    put(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    repeat (4) begin
      nop_i();
      nxt();
    end
  endtask

  initial begin
    nop_i();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pc_write", -1, if0.pc_write, 1);
    chk("rst_ifid_write", -1, if0.ifid_write, 1);
    chk("rst_idex_bubble", -1, if0.idex_bubble, 0);
    chk("rst_flush_ifid", -1, if0.flush_ifid, 0);
    chk("rst_fwd_a", -1, if0.fwd_a, 0);
    chk("rst_stall_cnt", -1, if0.stall_cnt, 0);
    nxt();
    reset = 1'b0;

    // 1: back-to-back dependency, then one instruction in between
    add_i(5'd5, 5'd1, 5'd2); nxt();
    add_i(5'd6, 5'd5, 5'd3); nxt();
    nop_i(); @(negedge clk);
    chk("t1_fwd_a_adjacent", 0, if0.fwd_a, 1);
    chk("t1_fwd_a_adjacent", 1, if1.fwd_a, 1);
    nxt(); drain();
    add_i(5'd5, 5'd1, 5'd2); nxt();
    add_i(5'd10, 5'd1, 5'd2); nxt();
    add_i(5'd6, 5'd5, 5'd3); nxt();
    nop_i(); @(negedge clk);
    chk("t1_fwd_a_gap", 0, if0.fwd_a, 2);
    chk("t1_fwd_b_gap", 0, if0.fwd_b, 0);
    nxt(); drain();

    // 2: load-use; ID held long enough for the LOAD_LAT=2 design
    ld_i(5'd7, 5'd1); nxt();
    add_i(5'd8, 5'd7, 5'd7); @(negedge clk);
    chk("t2_pc_write", 0, if0.pc_write, 0);
    chk("t2_idex_bubble", 0, if0.idex_bubble, 1);
    chk("t2_pc_write", 1, if1.pc_write, 0);
    nxt(); @(negedge clk);
    chk("t2_stall_over", 0, if0.pc_write, 1);
    chk("t2_stall_2nd", 1, if1.pc_write, 0);
    nxt(); @(negedge clk);
    chk("t2_fwd_a", 0, if0.fwd_a, 2);
    chk("t2_fwd_b", 0, if0.fwd_b, 2);
    chk("t2_stall_cnt", 0, if0.stall_cnt, 1);
    chk("t2_stall_over", 1, if1.pc_write, 1);
    nxt();
    nop_i(); @(negedge clk);
    chk("t2_fwd_a_lat2", 1, if1.fwd_a, 3);
    chk("t2_fwd_b_lat2", 1, if1.fwd_b, 3);
    chk("t2_stall_cnt_lat2", 1, if1.stall_cnt, 2);
    chk("t2_stall_cnt_hold", 0, if0.stall_cnt, 1);
    nxt(); drain();

    // 3: stall and taken branch together
    ld_i(5'd7, 5'd1); nxt();
    put(1'b1, 5'd8, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1); @(negedge clk);
    chk("t3_flush_ifid", 0, if0.flush_ifid, 1);
    chk("t3_pc_write", 0, if0.pc_write, 1);
    chk("t3_ifid_write", 0, if0.ifid_write, 1);
    chk("t3_idex_bubble", 0, if0.idex_bubble, 1);
    nxt();
    nop_i(); @(negedge clk);
    chk("t3_stall_cnt", 0, if0.stall_cnt, 1);
    chk("t3_flush_cnt", 0, if0.flush_cnt, 1);
    chk("t3_fwd_a_killed", 0, if0.fwd_a, 0);
    nxt(); drain();

    // 4: x0 never forwards or stalls
    add_i(5'd0, 5'd1, 5'd2); nxt();
    add_i(5'd6, 5'd0, 5'd0); nxt();
    nop_i(); @(negedge clk);
    chk("t4_fwd_a_x0", 0, if0.fwd_a, 0);
    chk("t4_fwd_b_x0", 0, if0.fwd_b, 0);
    nxt(); drain();
    ld_i(5'd0, 5'd1); nxt();
    add_i(5'd8, 5'd0, 5'd0); @(negedge clk);
    chk("t4_no_stall_x0", 0, if0.pc_write, 1);
    chk("t4_no_stall_x0", 1, if1.pc_write, 1);
    nxt(); drain();

    // 5: youngest of two producers wins
    add_i(5'd9, 5'd1, 5'd2); nxt();
    add_i(5'd9, 5'd3, 5'd4); nxt();
    add_i(5'd10, 5'd9, 5'd9); nxt();
    nop_i(); @(negedge clk);
    chk("t5_fwd_a_youngest", 0, if0.fwd_a, 1);
    chk("t5_fwd_b_youngest", 0, if0.fwd_b, 1);
    chk("t5_fwd_a_youngest", 1, if1.fwd_a, 1);
    nxt(); drain();

    // 6: reset in the middle of a stall
    ld_i(5'd7, 5'd1); nxt();
    add_i(5'd8, 5'd7, 5'd7); @(negedge clk);
    chk("t6_stalled", 0, if0.pc_write, 0);
    #1 reset = 1'b1;
    nxt();
    chk("t6_rst_pc_write", 0, if0.pc_write, 1);
    chk("t6_rst_stall_cnt", 0, if0.stall_cnt, 0);
    chk("t6_rst_flush_cnt", 0, if0.flush_cnt, 0);
    chk("t6_rst_pc_write", 1, if1.pc_write, 1);
    reset = 1'b0;
    drain();

    // saturation: 20 load-use stalls, then 17 flushes
    repeat (20) begin
      ld_i(5'd7, 5'd1); nxt();
      add_i(5'd8, 5'd7, 5'd7); nxt();
    end
    nop_i(); @(negedge clk);
    chk("sat_stall_cnt4", 2, if2.stall_cnt, 15);
    chk("sat_stall_cnt32", 0, if0.stall_cnt, 20);
    nxt();
    repeat (17) begin
      put(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); nxt();
    end
    nop_i(); @(negedge clk);
    chk("sat_flush_cnt4", 2, if2.flush_cnt, 15);
    chk("sat_flush_cnt32", 0, if0.flush_cnt, 17);
    nxt();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
